// File: rtl/key_event_sched.sv
// rtl/key_event_sched.sv - scan strobe generator and round-robin key event scheduler
module key_event_sched #(
    parameter int N_KEYS   = 4,
    parameter int SCAN_DIV = 1_000_000,
    parameter int CNT_W    = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_en,
    output logic              scan_tick,
    input  logic [N_KEYS-1:0] key_press,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [1:0]        evt_id,
    output logic [N_KEYS-1:0] evt_pending,
    output logic [N_KEYS-1:0] ovf_sticky,
    input  logic              ovf_clr
);

    typedef enum logic {IDLE, OFFER} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [1:0]       LAST_INIT = 2'(N_KEYS - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tick_q, tick_d;
    logic [N_KEYS-1:0] pend_q, pend_d;
    logic [N_KEYS-1:0] ovf_q, ovf_d;
    logic              valid_q, valid_d;
    logic [1:0]        id_q, id_d;
    logic [1:0]        last_q, last_d;
    logic [N_KEYS-1:0] acc_vec;
    logic              found;
    logic [1:0]        sel;

    // Tick is registered alongside the counter so it is high exactly while cnt_q==CNT_MAX.
    always_comb begin
        cnt_d = '0;
        if (scan_en) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
        tick_d = scan_en && (cnt_d == CNT_MAX);
    end

    always_comb begin
        acc_vec = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            acc_vec[i] = valid_q && evt_ready && (id_q == 2'(i));
        end
        // A press coinciding with its own accept re-arms the flag instead of overflowing.
        pend_d = key_press | (pend_q & ~acc_vec);
        ovf_d  = (ovf_q & ~{N_KEYS{ovf_clr}}) | (key_press & pend_q & ~acc_vec);
    end

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 1; k <= N_KEYS; k++) begin
            int idx;
            idx = (int'(last_q) + k) % N_KEYS;
            if (!found && pend_q[idx]) begin
                found = 1'b1;
                sel   = 2'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        id_d    = id_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (found) begin
                    id_d    = sel;
                    valid_d = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    valid_d = 1'b0;
                    last_d  = id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            last_q  <= LAST_INIT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    assign scan_tick   = tick_q;
    assign evt_valid   = valid_q;
    assign evt_id      = id_q;
    assign evt_pending = pend_q;
    assign ovf_sticky  = ovf_q;

endmodule

// File: tb/tb_key_event_sched.sv
// tb/tb_key_event_sched.sv - scoreboard bench for key_event_sched
module tb_key_event_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scan_en = 1'b0;
    logic       scan_tick;
    logic [3:0] key_press = '0;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [1:0] evt_id;
    logic [3:0] evt_pending;
    logic [3:0] ovf_sticky;
    logic       ovf_clr = 1'b0;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    key_event_sched #(.N_KEYS(4), .SCAN_DIV(10), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .scan_en(scan_en), .scan_tick(scan_tick),
        .key_press(key_press), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_id(evt_id), .evt_pending(evt_pending), .ovf_sticky(ovf_sticky),
        .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Every accepted event must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_evt", {30'b0, evt_id}, 32'hFFFF_FFFF);
            end else begin
                check_val("evt_id", {30'b0, evt_id}, 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] m);
        key_press = m;
        cyc();
        key_press = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cyc();
            n++;
        end
        check_val("drain", 32'(exp_q.size()), 0);
        repeat (3) cyc();
    endtask

    initial begin
        logic stable;
        repeat (2) cyc();
        rst = 1'b0;
        scan_en = 1'b1;
        check_val("rst_tick", {31'b0, scan_tick}, 0);
        check_val("rst_valid", {31'b0, evt_valid}, 0);
        check_val("rst_id", {30'b0, evt_id}, 0);
        check_val("rst_pend", {28'b0, evt_pending}, 0);
        check_val("rst_ovf", {28'b0, ovf_sticky}, 0);

        for (int c = 1; c <= 40; c++) begin
            cyc();
            if (c == 14) scan_en = 1'b0;
            if (c == 17) scan_en = 1'b1;
            check_val($sformatf("tick_c%0d", c), {31'b0, scan_tick},
                      (c == 9 || c == 26 || c == 36) ? 32'd1 : 32'd0);
        end
        scan_en = 1'b0;

        // single event
        evt_ready = 1'b1;
        exp_q.push_back(2);
        press(4'b0100);
        check_val("single_pend", {28'b0, evt_pending}, 4);
        check_val("single_valid_t1", {31'b0, evt_valid}, 0);
        cyc();
        check_val("single_valid_t2", {31'b0, evt_valid}, 1);
        check_val("single_id_t2", {30'b0, evt_id}, 2);
        cyc();
        check_val("single_valid_t3", {31'b0, evt_valid}, 0);
        check_val("single_pend_t3", {28'b0, evt_pending}, 0);
        check_val("single_ovf", {28'b0, ovf_sticky}, 0);
        wait_drain(10);

        // round robin
        do_reset();
        evt_ready = 1'b1;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        press(4'b1111);
        wait_drain(12);
        exp_q.push_back(0); exp_q.push_back(3);
        press(4'b1001);
        wait_drain(8);

        // backpressure
        evt_ready = 1'b0;
        exp_q.push_back(1);
        press(4'b0010);
        cyc();
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                exp_q.push_back(3);
                key_press = 4'b1000;
            end
            if (!(evt_valid === 1'b1 && evt_id === 2'd1)) stable = 1'b0;
            cyc();
            key_press = '0;
        end
        check_val("stall_stable", {31'b0, stable}, 1);
        check_val("stall_pend", {28'b0, evt_pending}, 4'b1010);
        evt_ready = 1'b1;
        wait_drain(10);

        // overflow
        do_reset();
        evt_ready = 1'b0;
        exp_q.push_back(0);
        press(4'b0001);
        press(4'b0001);
        check_val("ovf_set", {28'b0, ovf_sticky}, 1);
        evt_ready = 1'b1;
        wait_drain(10);
        repeat (4) cyc();
        check_val("ovf_pend_clear", {28'b0, evt_pending}, 0);
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        check_val("ovf_clr", {28'b0, ovf_sticky}, 0);
        evt_ready = 1'b0;
        exp_q.push_back(0);
        press(4'b0001);
        cyc();
        ovf_clr = 1'b1;
        press(4'b0001);
        ovf_clr = 1'b0;
        check_val("ovf_clr_race", {28'b0, ovf_sticky}, 1);
        evt_ready = 1'b1;
        wait_drain(10);

        // press coinciding with accept of the same key
        evt_ready = 1'b0;
        exp_q.push_back(2);
        press(4'b0100);
        cyc();
        check_val("sim_valid", {31'b0, evt_valid}, 1);
        exp_q.push_back(2);
        evt_ready = 1'b1;
        press(4'b0100);
        check_val("sim_pend", {28'b0, evt_pending}, 4);
        check_val("sim_ovf", {28'b0, ovf_sticky}, 1);
        wait_drain(10);

        // reset while offering
        evt_ready = 1'b0;
        press(4'b0010);
        cyc();
        check_val("mid_valid_pre", {31'b0, evt_valid}, 1);
        rst = 1'b1;
        #1;
        check_val("mid_valid", {31'b0, evt_valid}, 0);
        check_val("mid_id", {30'b0, evt_id}, 0);
        check_val("mid_pend", {28'b0, evt_pending}, 0);
        check_val("mid_ovf", {28'b0, ovf_sticky}, 0);
        check_val("mid_tick", {31'b0, scan_tick}, 0);
        cyc();
        rst = 1'b0;
        evt_ready = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (evt_valid !== 1'b0) stable = 1'b0;
            cyc();
        end
        check_val("post_rst_quiet", {31'b0, stable}, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_event_sched.md
Name: key_event_sched

Overview:
Scheduler between the 4-key debounce/edge-detect front end and a single event consumer (LED/mode control FSM).
- Generates the periodic scan strobe that paces key sampling.
- Latches per-key press pulses as pending requests.
- Grants them one at a time, round-robin, over a valid/ready handshake.
- Flags presses lost because the same key was already pending.

Parameters:
N_KEYS, 4, number of key request lines (evt_id width fixed at 2 bits, N_KEYS <= 4)
SCAN_DIV, 1_000_000, clk cycles per scan strobe (20 ms at 50 MHz)
CNT_W, 20, scan counter width, must hold SCAN_DIV-1

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous reset, active-high
scan_en  input  1  enables scan strobe generation
scan_tick  output  1  single-cycle strobe every SCAN_DIV cycles to the key sampler
key_press  input  N_KEYS  single-cycle press pulses from the edge detector, one bit per key
evt_valid  output  1  event offered to consumer
evt_ready  input  1  consumer accepts event
evt_id  output  2  index of the granted key, stable while evt_valid=1
evt_pending  output  N_KEYS  current pending request flags
ovf_sticky  output  N_KEYS  per-key sticky flag: a press was dropped
ovf_clr  input  1  clears all ovf_sticky bits

Behaviour:
- Reset (async, rst=1):
  - scan counter=0, scan_tick=0, evt_pending=0, ovf_sticky=0, evt_valid=0, evt_id=0.
  - last_grant=N_KEYS-1, so key 0 has first priority.
  - FSM=IDLE.
  - Reset mid-offer discards all pending events; no event is delivered after release until a new press arrives.
- Scan timer:
  - Counter runs 0..SCAN_DIV-1 and wraps to 0.
  - scan_tick=1 for exactly the cycle in which counter==SCAN_DIV-1 and scan_en=1. First tick occurs SCAN_DIV cycles after scan_en rises from reset.
  - scan_en=0 holds the counter at 0 and scan_tick at 0.
- Pending flags, per key i, each cycle:
  - set on key_press[i];
  - cleared on accept, i.e. evt_valid & evt_ready & evt_id==i.
  - Press and accept of the same key in the same cycle: pending stays 1. The new press is queued; no overflow.
  - Press while pending[i]=1 and not being accepted that cycle: press dropped, ovf_sticky[i]<=1.
- ovf_clr clears all ovf_sticky bits. An overflow set in the same cycle wins over the clear.
- FSM IDLE:
  - evt_valid=0.
  - If any pending bit is 1: select the first set bit searching upward from last_grant+1 modulo N_KEYS. Register it into evt_id, go to OFFER.
  - evt_ready is ignored in IDLE.
- FSM OFFER:
  - evt_valid=1; evt_id and evt_valid held until evt_ready=1.
  - On accept: clear that pending bit, last_grant<=evt_id, go to IDLE.
  - New presses during OFFER only update pending; they never change evt_id.
- Latency and throughput:
  - Press pulse in cycle t -> pending in t+1 -> evt_valid in t+2, when the FSM is IDLE and no other key is pending.
  - Mandatory one IDLE cycle between events; maximum 1 event per 2 cycles.
- Arbitration is starvation-free: with all keys continuously pending, each key is granted once per N_KEYS grants.
- All outputs are registered; no combinational path from evt_ready to evt_valid or evt_id.

Test Plan:
- Reset/timer: SCAN_DIV=10, scan_en=1 after reset -> scan_tick pulses on cycles 10, 20, 30 after reset release. Drop scan_en at cycle 15 -> no tick at 20; counter restarts at 0 when scan_en returns.
- Single event: pulse key_press=4'b0100 at t, evt_ready=1 -> evt_valid=1 with evt_id=2 at t+2, held one cycle; evt_pending returns to 0 at t+3; ovf_sticky=0.
- Round-robin: after reset pulse key_press=4'b1111 once, evt_ready=1 -> evt_id sequence 0,1,2,3 on alternating cycles. Then pulse 4'b1001 -> order 0,3 (last_grant=3 wraps to 0).
- Backpressure: key 1 pending, evt_ready=0 for 20 cycles -> evt_valid=1 and evt_id=1 stable throughout. Pulse key 3 during the stall -> evt_id stays 1; key 3 is granted after key 1 is accepted.
- Overflow: pulse key 0 twice while evt_ready=0 -> ovf_sticky=4'b0001, only one key-0 event delivered. Assert ovf_clr with no new overflow -> ovf_sticky=0. ovf_clr coincident with a key-0 overflow -> ovf_sticky stays 4'b0001.
- Simultaneous / reset: key-2 press in the same cycle its offer is accepted -> pending[2] stays 1, second key-2 event issued, no overflow. Assert rst while evt_valid=1 -> all outputs 0 asynchronously; no event after release.
